// File: rtl/acc_cmd_initiator.sv
// Host-side command initiator: queues host funct words, issues them one at a time
// to an accelerator, waits (with timeout) for its response and returns it with latency.
module acc_cmd_initiator #(
    parameter int unsigned CFG_REG_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [CFG_REG_WIDTH-1:0] req_funct,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic [31:0]              rsp_latency,
    output logic                     rsp_timeout,
    output logic                     idle,
    output logic                     acc_input_valid,
    input  logic                     acc_input_ready,
    output logic [CFG_REG_WIDTH-1:0] acc_funct,
    input  logic                     acc_output_valid,
    output logic                     acc_output_ready,
    input  logic [31:0]              acc_data_out,
    input  logic                     acc_busy
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [CFG_REG_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic [CFG_REG_WIDTH-1:0] acc_funct_q, acc_funct_d;
    logic                     acc_input_valid_q, acc_input_valid_d;
    logic                     acc_output_ready_q, acc_output_ready_d;
    logic [DATA_W-1:0]        lat_cnt_q, lat_cnt_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]        rsp_data_q, rsp_data_d;
    logic [DATA_W-1:0]        rsp_latency_q, rsp_latency_d;
    logic                     rsp_timeout_q, rsp_timeout_d;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic [DATA_W-1:0]        lat_next;

    // accelerator busy is informational only
    logic unused_acc_busy;
    assign unused_acc_busy = acc_busy;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == CNT_W'(0));
    assign push       = req_valid && !fifo_full;
    assign lat_next   = lat_cnt_q + DATA_W'(1);

    // Next-state, FIFO bookkeeping and response capture
    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        acc_funct_d   = acc_funct_q;
        lat_cnt_d     = lat_cnt_q;
        rsp_data_d    = rsp_data_q;
        rsp_latency_d = rsp_latency_q;
        rsp_timeout_d = rsp_timeout_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (acc_input_valid_q && acc_input_ready) begin
                    lat_cnt_d = '0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                lat_cnt_d = lat_next;
                // a real response beats a coincident timeout
                if (acc_output_valid) begin
                    rsp_data_d    = acc_data_out;
                    rsp_latency_d = lat_next;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (lat_next == DATA_W'(TIMEOUT_CYCLES)) begin
                    rsp_data_d    = '0;
                    rsp_latency_d = DATA_W'(TIMEOUT_CYCLES);
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            acc_funct_d = fifo_mem[rd_ptr_q];
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        acc_input_valid_d  = (state_d == ISSUE);
        acc_output_ready_d = (state_d == WAIT);
        rsp_valid_d        = (state_d == RESP);
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q            <= IDLE;
            wr_ptr_q           <= '0;
            rd_ptr_q           <= '0;
            count_q            <= '0;
            acc_funct_q        <= '0;
            acc_input_valid_q  <= 1'b0;
            acc_output_ready_q <= 1'b0;
            lat_cnt_q          <= '0;
            rsp_valid_q        <= 1'b0;
            rsp_data_q         <= '0;
            rsp_latency_q      <= '0;
            rsp_timeout_q      <= 1'b0;
        end else begin
            state_q            <= state_d;
            wr_ptr_q           <= wr_ptr_d;
            rd_ptr_q           <= rd_ptr_d;
            count_q            <= count_d;
            acc_funct_q        <= acc_funct_d;
            acc_input_valid_q  <= acc_input_valid_d;
            acc_output_ready_q <= acc_output_ready_d;
            lat_cnt_q          <= lat_cnt_d;
            rsp_valid_q        <= rsp_valid_d;
            rsp_data_q         <= rsp_data_d;
            rsp_latency_q      <= rsp_latency_d;
            rsp_timeout_q      <= rsp_timeout_d;
        end
    end

    // Queue storage needs no reset: the pointers define what is valid
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= req_funct;
        end
    end

    assign req_ready        = !fifo_full;
    assign idle             = (state_q == IDLE) && fifo_empty;
    assign acc_funct        = acc_funct_q;
    assign acc_input_valid  = acc_input_valid_q;
    assign acc_output_ready = acc_output_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_data         = rsp_data_q;
    assign rsp_latency      = rsp_latency_q;
    assign rsp_timeout      = rsp_timeout_q;

endmodule

// File: tb/tb_acc_cmd_initiator.sv
// Scoreboard bench for acc_cmd_initiator: directed commands, a latency-programmable
// accelerator model, and a second instance with a short timeout.
module tb_acc_cmd_initiator;

    typedef struct {
        logic [31:0] data;
        logic [31:0] lat;
        logic        to;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_funct;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] rsp_latency;
    logic        rsp_timeout;
    logic        idle;
    logic        acc_input_valid;
    logic        acc_input_ready;
    logic [31:0] acc_funct;
    logic        acc_output_valid;
    logic        acc_output_ready;
    logic [31:0] acc_data_out;

    logic        t_req_valid;
    logic        t_req_ready;
    logic [31:0] t_req_funct;
    logic        t_rsp_valid;
    logic [31:0] t_rsp_data;
    logic [31:0] t_rsp_latency;
    logic        t_rsp_timeout;
    logic        t_idle;
    logic        t_acc_input_valid;
    logic [31:0] t_acc_funct;
    logic        t_acc_output_ready;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];

    int          model_lat = 4;
    logic [31:0] model_data = 32'h6;
    logic        model_from_funct = 1'b0;

    acc_cmd_initiator #(.CFG_REG_WIDTH(32), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(1024)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_latency(rsp_latency), .rsp_timeout(rsp_timeout), .idle(idle),
        .acc_input_valid(acc_input_valid), .acc_input_ready(acc_input_ready),
        .acc_funct(acc_funct), .acc_output_valid(acc_output_valid),
        .acc_output_ready(acc_output_ready), .acc_data_out(acc_data_out),
        .acc_busy(1'b0)
    );

    // Accelerator that never answers, so every command times out
    acc_cmd_initiator #(.CFG_REG_WIDTH(32), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) u_to (
        .clock(clock), .reset(reset),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_funct(t_req_funct),
        .rsp_valid(t_rsp_valid), .rsp_ready(1'b1), .rsp_data(t_rsp_data),
        .rsp_latency(t_rsp_latency), .rsp_timeout(t_rsp_timeout), .idle(t_idle),
        .acc_input_valid(t_acc_input_valid), .acc_input_ready(1'b1),
        .acc_funct(t_acc_funct), .acc_output_valid(1'b0),
        .acc_output_ready(t_acc_output_ready), .acc_data_out(32'hDEAD_BEEF),
        .acc_busy(1'b1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h want=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] f);
        int n = 0;
        req_valid = 1'b1;
        req_funct = f;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        chk("push_accepted", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic expect_rsp(input logic [31:0] d, input logic [31:0] l, input logic t);
        exp_t e;
        e.data = d;
        e.lat  = l;
        e.to   = t;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!(idle && exp_q.size() == 0) && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    // Accelerator model: answers model_lat cycles after the command handshake
    initial begin
        logic [31:0] word;
        int          lat;
        acc_output_valid = 1'b0;
        acc_data_out     = '0;
        forever begin
            @(negedge clock);
            if (!reset && acc_input_valid && acc_input_ready) begin
                word = model_from_funct ? acc_funct + 32'h100 : model_data;
                lat  = model_lat;
                @(posedge clock);
                @(negedge clock);
                chk("issue_dropped", 32'(acc_input_valid), 32'd0);
                chk("wait_out_ready", 32'(acc_output_ready), 32'd1);
                if (lat >= 2) begin
                    repeat (lat - 1) @(posedge clock);
                    #1;
                    acc_output_valid = 1'b1;
                    acc_data_out     = word;
                    @(posedge clock);
                    #1;
                    acc_output_valid = 1'b0;
                    acc_data_out     = '0;
                end
            end
        end
    end

    // Monitor: every presented response is checked against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && rsp_valid) begin
                chk("rsp_no_issue", 32'(acc_input_valid), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp got data=0x%08h lat=%0d to=%0d want no response",
                             rsp_data, rsp_latency, rsp_timeout);
                end else begin
                    e = exp_q[0];
                    chk(rsp_ready ? "rsp_data" : "hold_data", rsp_data, e.data);
                    chk(rsp_ready ? "rsp_latency" : "hold_latency", rsp_latency, e.lat);
                    chk(rsp_ready ? "rsp_timeout" : "hold_timeout", 32'(rsp_timeout), 32'(e.to));
                    if (rsp_ready) e = exp_q.pop_front();
                end
            end
        end
    end

    initial begin
        int          n;
        int          nrsp;
        logic [31:0] issued[$];
        reset           = 1'b1;
        req_valid       = 1'b0;
        req_funct       = '0;
        rsp_ready       = 1'b1;
        acc_input_ready = 1'b1;
        t_req_valid     = 1'b0;
        t_req_funct     = '0;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_acc_in_valid", 32'(acc_input_valid), 32'd0);
        chk("rst_acc_out_ready", 32'(acc_output_ready), 32'd0);
        chk("rst_acc_funct", acc_funct, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_latency", rsp_latency, 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        reset = 1'b0;
        tick();

        // CONFIG, 4-cycle response
        model_lat = 4;
        expect_rsp(32'h6, 32'd4, 1'b0);
        push(32'd1);
        wait_done(100, "done_config");

        // COMPUTE, 500-cycle response
        model_lat = 500;
        expect_rsp(32'h6, 32'd500, 1'b0);
        push(32'd2);
        wait_done(700, "done_compute");

        // Five back-to-back pushes against a stalled accelerator
        model_lat        = 3;
        model_from_funct = 1'b1;
        acc_input_ready  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_rsp(32'h111 + 32'(i), 32'd3, 1'b0);
            push(32'h11 + 32'(i));
        end
        chk("full_req_ready", 32'(req_ready), 32'd0);
        chk("stall_in_valid", 32'(acc_input_valid), 32'd1);
        chk("stall_funct", acc_funct, 32'h11);
        repeat (3) tick();
        chk("stall_funct_hold", acc_funct, 32'h11);
        acc_input_ready = 1'b1;
        wait_done(200, "done_order");
        model_from_funct = 1'b0;

        // Host back-pressure on the response
        model_lat = 2;
        rsp_ready = 1'b0;
        expect_rsp(32'h6, 32'd2, 1'b0);
        expect_rsp(32'h6, 32'd2, 1'b0);
        push(32'h21);
        push(32'h22);
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        repeat (10) begin
            tick();
            chk("bp_no_issue", 32'(acc_input_valid), 32'd0);
            chk("bp_rsp_held", 32'(rsp_valid), 32'd1);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_next_issue", 32'(acc_input_valid), 32'd1);
        chk("bp_next_funct", acc_funct, 32'h22);
        wait_done(100, "done_bp");

        // Response coinciding with the timeout edge counts as data
        model_lat = 1024;
        expect_rsp(32'h6, 32'd1024, 1'b0);
        push(32'd2);
        wait_done(1200, "done_edge");

        // Reset while waiting with two commands queued
        model_lat = 20;
        push(32'h31);
        push(32'h32);
        push(32'h33);
        repeat (3) tick();
        chk("pre_rst_wait", 32'(acc_output_ready), 32'd1);
        chk("pre_rst_busy", 32'(idle), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_idle", 32'(idle), 32'd1);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_out_ready", 32'(acc_output_ready), 32'd0);
        repeat (25) begin
            tick();
            chk("post_rst_quiet", 32'({rsp_valid, acc_input_valid}), 32'd0);
        end
        chk("post_rst_idle", 32'(idle), 32'd1);

        // Timeout instance: two commands, both time out after 16 cycles
        t_req_valid = 1'b1;
        t_req_funct = 32'h41;
        tick();
        t_req_funct = 32'h42;
        tick();
        t_req_valid = 1'b0;
        nrsp = 0;
        for (int c = 0; c < 100; c++) begin
            if (t_acc_input_valid && (issued.size() == 0 || nrsp == issued.size()))
                issued.push_back(t_acc_funct);
            if (t_rsp_valid) begin
                chk("to_data", t_rsp_data, 32'd0);
                chk("to_latency", t_rsp_latency, 32'd16);
                chk("to_flag", 32'(t_rsp_timeout), 32'd1);
                nrsp++;
            end
            tick();
        end
        chk("to_rsp_count", 32'(nrsp), 32'd2);
        chk("to_issue_count", 32'(issued.size()), 32'd2);
        if (issued.size() == 2) begin
            chk("to_issue0", issued[0], 32'h41);
            chk("to_issue1", issued[1], 32'h42);
        end
        chk("to_idle", 32'(t_idle), 32'd1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_cmd_initiator.md
ACC_CMD_INITIATOR -- requirements
Module: acc_cmd_initiator

Interface
- REQ-001 SHALL have parameter CFG_REG_WIDTH, default 32, width of the funct command word.
- REQ-002 SHALL have parameter FIFO_DEPTH, default 4, command queue entries (power of two, >=2).
- REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum wait for a response, >=2.
- REQ-004 SHALL have port clock, input, 1, single clock; all logic on rising edge.
- REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
- REQ-006 SHALL have port req_valid, input, 1, host command offered.
- REQ-007 SHALL have port req_ready, output, 1, queue can accept a command.
- REQ-008 SHALL have port req_funct, input, CFG_REG_WIDTH, command funct (1=CONFIG, 2=COMPUTE, others passed through).
- REQ-009 SHALL have port rsp_valid, output, 1, result available to host.
- REQ-010 SHALL have port rsp_ready, input, 1, host accepts result.
- REQ-011 SHALL have port rsp_data, output, 32, captured accelerator data.
- REQ-012 SHALL have port rsp_latency, output, 32, cycles from command handshake to response handshake.
- REQ-013 SHALL have port rsp_timeout, output, 1, result is a timeout, not accelerator data.
- REQ-014 SHALL have port idle, output, 1, FSM in IDLE and queue empty.
- REQ-015 SHALL have port acc_input_valid, output, 1, command valid to accelerator.
- REQ-016 SHALL have port acc_input_ready, input, 1, accelerator accepts command.
- REQ-017 SHALL have port acc_funct, output, CFG_REG_WIDTH, funct driven to accelerator.
- REQ-018 SHALL have port acc_output_valid, input, 1, accelerator response valid.
- REQ-019 SHALL have port acc_output_ready, output, 1, initiator accepts response.
- REQ-020 SHALL have port acc_data_out, input, 32, accelerator response data.
- REQ-021 SHALL have port acc_busy, input, 1, accelerator busy (status only, no control effect).

Function
- REQ-022 SHALL push req_funct into the FIFO when req_valid && req_ready; req_ready = queue not full (no bypass when full).
- REQ-023 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
- REQ-024 SHALL go IDLE->ISSUE when queue non-empty, popping the head into acc_funct register in that same edge.
- REQ-025 SHALL in ISSUE hold acc_input_valid=1 and acc_funct stable until acc_input_valid && acc_input_ready at an edge, then go to WAIT with latency counter = 0.
- REQ-026 SHALL in WAIT drive acc_output_ready=1 and increment latency counter each cycle.
- REQ-027 SHALL on acc_output_valid in WAIT capture rsp_data=acc_data_out, rsp_latency=counter+1, rsp_timeout=0, go to RESP.
- REQ-028 SHALL, if counter+1 reaches TIMEOUT_CYCLES in WAIT without response, go to RESP with rsp_data=0, rsp_latency=TIMEOUT_CYCLES, rsp_timeout=1.
- REQ-029 SHALL treat acc_output_valid and timeout in the same cycle as a valid response (REQ-027 wins).
- REQ-030 SHALL in RESP hold rsp_valid=1 and rsp_* stable until rsp_ready; then go ISSUE (popping head) if queue non-empty, else IDLE.
- REQ-031 SHALL keep acc_output_ready=0 outside WAIT; acc_output_valid outside WAIT is ignored.
- REQ-032 SHALL permit simultaneous push and pop in one cycle; occupancy unchanged, FIFO order preserved across pointer wrap.
- REQ-033 SHALL drive acc_input_valid=0 in all states except ISSUE.

Reset
- REQ-034 SHALL on reset, at the next edge, go IDLE, empty the FIFO, set counter=0, and set req_ready=1, rsp_valid=0, rsp_data=0, rsp_latency=0, rsp_timeout=0, idle=1, acc_input_valid=0, acc_funct=0, acc_output_ready=0.
- REQ-035 SHALL on reset mid-operation (any state) discard the in-flight command and all queued commands with no rsp_valid pulse.

Verification
- REQ-036 SHALL cover: push funct=1; model acc ready immediately, responds 4 cycles after handshake with data 0x06 -> one rsp_valid, rsp_data=0x06, rsp_latency=4, rsp_timeout=0.
- REQ-037 SHALL cover: push funct=2, model latency 500 -> rsp_latency=500, data 0x06; acc_input_valid dropped the cycle after handshake.
- REQ-038 SHALL cover: push 5 commands back-to-back with FIFO_DEPTH=4 and acc_input_ready=0 -> req_ready=0 after 4th accepted push plus one popped, responses returned in push order.
- REQ-039 SHALL cover: model never responds, TIMEOUT_CYCLES=16 -> rsp_timeout=1, rsp_data=0, rsp_latency=16; next queued command then issues.
- REQ-040 SHALL cover: rsp_ready held 0 for 10 cycles in RESP -> rsp_* stable, no new acc_input_valid; then release -> next command issues.
- REQ-041 SHALL cover: reset asserted in WAIT with 2 queued -> next cycle idle=1, no rsp_valid, late acc_output_valid ignored.
